// File: rtl/sensor_spi_arbiter.sv
// Round-robin arbiter sharing one spi_master between two bno085 controllers.
// A controller's cs_n low is its request; the granted side sees the master handshake.
module sensor_spi_arbiter #(
    parameter int unsigned GAP_CYCLES     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 300000
) (
    input  logic       clk,
    input  logic       fpga_rst_n,
    input  logic [1:0] req_cs_n,
    input  logic [1:0] req_start,
    input  logic [1:0] req_tx_valid,
    input  logic [7:0] req_tx_data0,
    input  logic [7:0] req_tx_data1,
    output logic [1:0] req_tx_ready,
    output logic [1:0] req_rx_valid,
    output logic [7:0] req_rx_data0,
    output logic [7:0] req_rx_data1,
    output logic [1:0] req_busy,
    output logic       m_start,
    output logic       m_tx_valid,
    output logic [7:0] m_tx_data,
    input  logic       m_tx_ready,
    input  logic       m_rx_valid,
    input  logic       m_busy,
    input  logic [7:0] m_rx_data,
    output logic       cs_n0,
    output logic       cs_n1,
    output logic [1:0] grant,
    output logic       timeout_err
);

    localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned TmoW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES - 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StGranted, StGap} state_e;

    state_e          state_q;
    logic [1:0]      grant_q;
    logic            rr_ptr_q;
    logic [GapW-1:0] gap_cnt_q;
    logic [TmoW-1:0] tmo_cnt_q;
    logic            timeout_err_q;
    logic [1:0]      blocked_q;

    logic       granted;
    logic       gidx;
    logic [1:0] eff_req;
    logic       tmo_hit;
    logic       release_now;

    assign granted     = (state_q == StGranted);
    assign gidx        = grant_q[1];
    assign eff_req     = ~req_cs_n & ~blocked_q;
    assign tmo_hit     = granted && (tmo_cnt_q == TmoLast);
    assign release_now = granted && ((req_cs_n[gidx] && !m_busy) || tmo_hit);

    always_ff @(posedge clk or negedge fpga_rst_n) begin
        if (!fpga_rst_n) begin
            state_q       <= StIdle;
            grant_q       <= 2'b00;
            rr_ptr_q      <= 1'b0;
            gap_cnt_q     <= '0;
            tmo_cnt_q     <= '0;
            timeout_err_q <= 1'b0;
            blocked_q     <= 2'b00;
        end else begin
            // A timed-out requester stays locked out until its cs_n has gone high once.
            blocked_q <= (tmo_hit ? grant_q : 2'b00) | (blocked_q & ~req_cs_n);
            case (state_q)
                StIdle: begin
                    if (|eff_req) begin
                        state_q   <= StGranted;
                        tmo_cnt_q <= '0;
                        if (eff_req == 2'b11) begin
                            grant_q <= rr_ptr_q ? 2'b10 : 2'b01;
                        end else begin
                            grant_q <= eff_req;
                        end
                    end
                end
                StGranted: begin
                    if (release_now) begin
                        state_q   <= StGap;
                        grant_q   <= 2'b00;
                        rr_ptr_q  <= ~gidx;
                        gap_cnt_q <= '0;
                        if (tmo_hit) begin
                            timeout_err_q <= 1'b1;
                        end
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
                end
                StGap: begin
                    if (gap_cnt_q == GapLast) begin
                        state_q <= StIdle;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    grant_q <= 2'b00;
                end
            endcase
        end
    end

    always_comb begin
        cs_n0        = 1'b1;
        cs_n1        = 1'b1;
        m_start      = 1'b0;
        m_tx_valid   = 1'b0;
        m_tx_data    = 8'h00;
        req_tx_ready = 2'b00;
        req_rx_valid = 2'b00;
        req_rx_data0 = 8'h00;
        req_rx_data1 = 8'h00;
        req_busy     = 2'b11;
        if (granted) begin
            if (gidx) begin
                cs_n1           = req_cs_n[1];
                m_start         = req_start[1];
                m_tx_valid      = req_tx_valid[1];
                m_tx_data       = req_tx_data1;
                req_tx_ready[1] = m_tx_ready;
                req_rx_valid[1] = m_rx_valid;
                req_rx_data1    = m_rx_data;
                req_busy[1]     = m_busy;
            end else begin
                cs_n0           = req_cs_n[0];
                m_start         = req_start[0];
                m_tx_valid      = req_tx_valid[0];
                m_tx_data       = req_tx_data0;
                req_tx_ready[0] = m_tx_ready;
                req_rx_valid[0] = m_rx_valid;
                req_rx_data0    = m_rx_data;
                req_busy[0]     = m_busy;
            end
        end
    end

    assign grant       = grant_q;
    assign timeout_err = timeout_err_q;

endmodule
